// File: rtl/apb_arb_pkg.sv
// Shared constants and helpers for the APB master arbiter.
// State encoding is plain localparams so older tools can consume it unchanged.
package apb_arb_pkg;

    localparam int unsigned NReqMax = 8;

    typedef logic [1:0] state_t;

    localparam state_t StIdle  = 2'd0;
    localparam state_t StIssue = 2'd1;
    localparam state_t StWait  = 2'd2;
    localparam state_t StResp  = 2'd3;

    // Index width for n requesters, never below one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/apb_rr_pick.sv
// Combinational rotate-priority picker: first valid requester at or after ptr_i wins.
module apb_rr_pick
    import apb_arb_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  valid_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    int unsigned k;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        k       = 0;
        for (int unsigned i = 0; i < N; i++) begin
            k = (32'(ptr_i) + i) % N;
            if (!any_o && valid_i[IW'(k)]) begin
                any_o              = 1'b1;
                grant_o[IW'(k)]    = 1'b1;
                idx_o              = IW'(k);
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one apb_master command port between N_REQ requesters.
// Optional grant locking is enabled by defining APB_ARB_LOCK_EN.
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic [N_REQ-1:0]    i_req_valid,
    output logic [N_REQ-1:0]    o_req_ready,
    input  logic [N_REQ-1:0]    i_req_write,
    input  logic [N_REQ*AW-1:0] i_req_addr,
    input  logic [N_REQ*DW-1:0] i_req_wdata,
    input  logic [N_REQ-1:0]    i_req_lock,
    output logic [N_REQ-1:0]    o_rsp_valid,
    output logic [DW-1:0]       o_rsp_rdata,
    output logic                o_rsp_slverr,
    output logic                o_start,
    output logic [AW-1:0]       o_addr,
    output logic [DW-1:0]       o_wdata,
    output logic                o_write,
    input  logic                i_done,
    input  logic [DW-1:0]       i_rdata,
    input  logic                i_slverr
);

    localparam int unsigned IW = idx_w(N_REQ);

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic            write_q, write_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            slverr_q, slverr_d;
    logic            lock_q, lock_d;

    logic [N_REQ-1:0] pick_valid;
    logic [N_REQ-1:0] grant;
    logic [N_REQ-1:0] owner_oh;
    logic [IW-1:0]    grant_idx;
    logic             grant_any;

    logic [AW-1:0] addr_arr  [N_REQ];
    logic [DW-1:0] wdata_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = i_req_addr[g*AW +: AW];
        assign wdata_arr[g] = i_req_wdata[g*DW +: DW];
    end

    assign owner_oh = N_REQ'(1) << owner_q;

`ifdef APB_ARB_LOCK_EN
    // A held lock narrows arbitration to the owner while it keeps requesting.
    assign pick_valid = (lock_q && i_req_valid[owner_q]) ? (i_req_valid & owner_oh) : i_req_valid;
`else
    logic unused_lock;
    assign unused_lock = ^i_req_lock;
    assign pick_valid  = i_req_valid;
`endif

    apb_rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_pick (
        .valid_i (pick_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .idx_o   (grant_idx),
        .any_o   (grant_any)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        slverr_d = slverr_q;
        lock_d   = lock_q;
        case (state_q)
            StIdle: begin
`ifdef APB_ARB_LOCK_EN
                if (lock_q && !i_req_valid[owner_q]) begin
                    lock_d = 1'b0;
                end
`endif
                if (grant_any) begin
                    owner_d = grant_idx;
                    write_d = i_req_write[grant_idx];
                    addr_d  = addr_arr[grant_idx];
                    wdata_d = wdata_arr[grant_idx];
`ifdef APB_ARB_LOCK_EN
                    lock_d  = i_req_lock[grant_idx];
`else
                    lock_d  = 1'b0;
`endif
                    state_d = StIssue;
                end
            end
            StIssue: begin
                state_d = StWait;
            end
            StWait: begin
                if (i_done) begin
                    rdata_d  = i_rdata;
                    slverr_d = i_slverr;
                    state_d  = StResp;
                end
            end
            StResp: begin
                if (lock_q) begin
                    ptr_d = owner_q;
                end else if (owner_q == IW'(N_REQ - 1)) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = owner_q + 1'b1;
                end
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            owner_q  <= '0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            slverr_q <= 1'b0;
            lock_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            slverr_q <= slverr_d;
            lock_q   <= lock_d;
        end
    end

    assign o_req_ready  = (state_q == StIdle) ? grant : '0;
    assign o_start      = (state_q == StIssue);
    assign o_addr       = addr_q;
    assign o_wdata      = wdata_q;
    assign o_write      = write_q;
    assign o_rsp_valid  = (state_q == StResp) ? owner_oh : '0;
    assign o_rsp_rdata  = rdata_q;
    assign o_rsp_slverr = slverr_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Scoreboard bench for apb_master_arbiter: stimulus pushes expectations, a monitor checks them.
module tb_apb_master_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    o_req_ready;
    logic [N-1:0]    req_write;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    req_lock;
    logic [N-1:0]    o_rsp_valid;
    logic [DW-1:0]   o_rsp_rdata;
    logic            o_rsp_slverr;
    logic            o_start;
    logic [AW-1:0]   o_addr;
    logic [DW-1:0]   o_wdata;
    logic            o_write;
    logic            i_done;
    logic [DW-1:0]   i_rdata;
    logic            i_slverr;

    always #5 clk = ~clk;

    apb_master_arbiter #(
        .N_REQ (N),
        .AW    (AW),
        .DW    (DW)
    ) dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_req_valid  (req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_write  (req_write),
        .i_req_addr   (req_addr),
        .i_req_wdata  (req_wdata),
        .i_req_lock   (req_lock),
        .o_rsp_valid  (o_rsp_valid),
        .o_rsp_rdata  (o_rsp_rdata),
        .o_rsp_slverr (o_rsp_slverr),
        .o_start      (o_start),
        .o_addr       (o_addr),
        .o_wdata      (o_wdata),
        .o_write      (o_write),
        .i_done       (i_done),
        .i_rdata      (i_rdata),
        .i_slverr     (i_slverr)
    );

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        lock;
    } item_t;

    typedef struct {
        int          owner;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    item_t pend [N][$];
    exp_t  exp_start [$];
    exp_t  exp_rsp [$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc_cyc = -10;
    int done_cyc = -10;
    int rst_gen = 0;

    int          slv_lat = 2;
    logic        slv_err = 1'b0;
    logic        slv_early = 1'b0;
    logic [31:0] slv_xor = 32'h5A5A_0000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Queue a request and its expected start/response; call order is the expected grant order.
    task automatic send(input int k, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic lock);
        item_t it;
        exp_t  e;
        it.write = wr;
        it.addr  = addr;
        it.wdata = wdata;
        it.lock  = lock;
        pend[k].push_back(it);
        e.owner = k;
        e.write = wr;
        e.addr  = addr;
        e.wdata = wdata;
        e.rdata = addr ^ slv_xor;
        e.err   = slv_err;
        exp_start.push_back(e);
        exp_rsp.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_rsp.size() != 0 || exp_start.size() != 0) && n < 400) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (n >= 400) begin
            failures++;
            $display("FAIL drain_timeout pending_start=%0d pending_rsp=%0d",
                     exp_start.size(), exp_rsp.size());
            exp_start.delete();
            exp_rsp.delete();
        end
        repeat (3) @(posedge clk);
    endtask

    // Requester driver: present the head of each queue, retire it when accepted.
    logic [N-1:0] acc;
    item_t        drv_it;
    initial begin
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_lock  = '0;
        forever begin
            @(negedge clk);
            acc = req_valid & o_req_ready;
            if (acc != '0) acc_cyc = cyc;
            @(posedge clk);
            #1;
            for (int k = 0; k < N; k++) begin
                if (acc[k]) begin
                    req_valid[k] = 1'b0;
                    void'(pend[k].pop_front());
                end
                if (!req_valid[k] && pend[k].size() > 0) begin
                    drv_it = pend[k][0];
                    req_write[k]           = drv_it.write;
                    req_addr[k*AW +: AW]   = drv_it.addr;
                    req_wdata[k*DW +: DW]  = drv_it.wdata;
                    req_lock[k]            = drv_it.lock;
                    req_valid[k]           = 1'b1;
                end
            end
        end
    end

    // apb_master model: done after slv_lat cycles, optional bogus done during ISSUE.
    logic [31:0] slv_a;
    int          slv_g;
    initial begin
        i_done   = 1'b0;
        i_rdata  = '0;
        i_slverr = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && o_start) begin
                slv_a = o_addr;
                slv_g = rst_gen;
                if (slv_early) begin
                    i_done   = 1'b1;
                    i_rdata  = 32'hBAD0_BAD0;
                    i_slverr = ~slv_err;
                end
                @(posedge clk);
                #1;
                i_done   = 1'b0;
                i_slverr = 1'b0;
                for (int i = 1; i < slv_lat; i++) begin
                    if (slv_g != rst_gen) break;
                    @(posedge clk);
                    #1;
                end
                if (slv_g == rst_gen) begin
                    i_done   = 1'b1;
                    i_rdata  = slv_a ^ slv_xor;
                    i_slverr = slv_err;
                    done_cyc = cyc;
                    @(posedge clk);
                    #1;
                    i_done   = 1'b0;
                    i_slverr = 1'b0;
                end
            end
        end
    end

    // Monitor: compares starts and responses against the scoreboard queues.
    exp_t mon_e;
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("ready_onehot0", 64'($onehot0(o_req_ready)), 64'd1);
                check("ready_subset", 64'(o_req_ready & ~req_valid), 64'd0);
                if (o_start) begin
                    if (exp_start.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL start_unexpected addr=%0h", o_addr);
                    end else begin
                        mon_e = exp_start.pop_front();
                        check("start_addr", 64'(o_addr), 64'(mon_e.addr));
                        check("start_wdata", 64'(o_wdata), 64'(mon_e.wdata));
                        check("start_write", 64'(o_write), 64'(mon_e.write));
                        check("start_latency", 64'(cyc - acc_cyc), 64'd1);
                    end
                end
                if (o_rsp_valid != '0) begin
                    if (exp_rsp.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL rsp_unexpected valid=%0h", o_rsp_valid);
                    end else begin
                        mon_e = exp_rsp.pop_front();
                        check("rsp_owner", 64'(o_rsp_valid), 64'(1) << mon_e.owner);
                        check("rsp_rdata", 64'(o_rsp_rdata), 64'(mon_e.rdata));
                        check("rsp_slverr", 64'(o_rsp_slverr), 64'(mon_e.err));
                        check("rsp_latency", 64'(cyc - done_cyc), 64'd1);
                        check("rsp_addr_held", 64'(o_addr), 64'(mon_e.addr));
                    end
                end
            end
        end
    end

    int wait_n;
    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_start", 64'(o_start), 64'd0);
        check("rst_ready", 64'(o_req_ready), 64'd0);
        check("rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
        check("rst_addr", 64'(o_addr), 64'd0);
        check("rst_wdata", 64'(o_wdata), 64'd0);
        check("rst_write", 64'(o_write), 64'd0);
        check("rst_rdata", 64'(o_rsp_rdata), 64'd0);
        check("rst_slverr", 64'(o_rsp_slverr), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Single write from requester 0.
        send(0, 1'b1, 32'h10, 32'hA5, 1'b0);
        drain();

        // Read from requester 2 with error; slave returns 0xDEADBEEF.
        slv_xor = 32'hDEAD_BECF;
        slv_err = 1'b1;
        send(2, 1'b0, 32'h20, 32'h0, 1'b0);
        check("t3_expected_rdata", 64'(exp_rsp[0].rdata), 64'hDEAD_BEEF);
        drain();
        slv_xor = 32'h5A5A_0000;
        slv_err = 1'b0;

        // Spurious done during ISSUE must be ignored.
        slv_early = 1'b1;
        slv_lat   = 3;
        send(3, 1'b1, 32'h30, 32'h33, 1'b0);
        drain();
        slv_early = 1'b0;
        slv_lat   = 2;

        // Pointer is now 0: all four valid, grant order 0,1,2,3,0.
        send(0, 1'b1, 32'h100, 32'h1000, 1'b0);
        send(1, 1'b0, 32'h110, 32'h1100, 1'b0);
        send(2, 1'b1, 32'h120, 32'h1200, 1'b0);
        send(3, 1'b0, 32'h130, 32'h1300, 1'b0);
        send(0, 1'b0, 32'h104, 32'h1004, 1'b0);
        drain();

        // Move pointer to 3, then abort a requester-3 transfer with reset during WAIT.
        send(2, 1'b0, 32'h200, 32'h0, 1'b0);
        drain();
        slv_lat = 12;
        send(3, 1'b1, 32'h300, 32'h3C, 1'b0);
        wait_n = 0;
        while (wait_n < 40) begin
            @(negedge clk);
            if (o_start) break;
            wait_n++;
        end
        if (wait_n >= 40) begin
            checks++;
            failures++;
            $display("FAIL t4_start_timeout cycles=%0d", wait_n);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        rst_gen++;
        #1;
        check("t4_start", 64'(o_start), 64'd0);
        check("t4_addr", 64'(o_addr), 64'd0);
        check("t4_wdata", 64'(o_wdata), 64'd0);
        check("t4_write", 64'(o_write), 64'd0);
        check("t4_rsp_valid", 64'(o_rsp_valid), 64'd0);
        void'(exp_rsp.pop_back());
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        slv_lat = 2;
        repeat (3) @(posedge clk);
        // Pointer back at 0 after reset: requester 1 beats requester 3.
        send(1, 1'b1, 32'h410, 32'h4100, 1'b0);
        send(3, 1'b0, 32'h430, 32'h4300, 1'b0);
        drain();

`ifdef APB_ARB_LOCK_EN
        // Pointer to 1, then requester 1 locks for two transfers; order 1,1,1,3,0.
        send(0, 1'b1, 32'h500, 32'h5000, 1'b0);
        drain();
        send(1, 1'b1, 32'h510, 32'h5100, 1'b1);
        send(1, 1'b1, 32'h514, 32'h5140, 1'b1);
        send(1, 1'b0, 32'h518, 32'h5180, 1'b0);
        send(3, 1'b1, 32'h530, 32'h5300, 1'b0);
        send(0, 1'b0, 32'h504, 32'h5040, 1'b0);
        drain();
`endif

        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
